// File: rtl/larson_pattern_decoder.sv
// Larson scanner pattern decoder: recovers position, direction and lock
// from a looped-back bounce pattern, flagging and counting illegal samples.
module larson_pattern_decoder #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8,
  localparam int N  = 2*WIDTH-2,
  localparam int SW = $clog2(N),
  localparam int PW = $clog2(WIDTH)
) (
  input  logic                 slowclk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     pattern_in,
  input  logic                 pattern_valid,
  output logic [SW-1:0]        state_out,
  output logic                 dir_out,
  output logic                 locked,
  output logic                 stall,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_SYNC,
    S_LOCK
  } fsm_t;

  fsm_t                 fsm, fsm_n;
  logic [PW-1:0]        prev_p, prev_n;
  logic [SW-1:0]        state_n, nxt, lock_s;
  logic                 dir_n, locked_n, stall_n, error_n;
  logic [ERR_CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0]     pat_cur, pat_nxt;
  logic [PW-1:0]        p;
  logic                 onehot, adj_up, adj_dn;

  // Scanner state s lights bit s going up and bit N-s coming back.
  function automatic logic [WIDTH-1:0] pat_of(input logic [SW-1:0] s);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++)
      v[i] = (int'(s) == i) || (int'(s) == N - i);
    return v;
  endfunction

  function automatic logic dir_of(input logic [SW-1:0] s);
    return int'(s) <= WIDTH - 2;
  endfunction

  always_comb begin
    onehot = (pattern_in != '0) &&
             ((pattern_in & (pattern_in - WIDTH'(1))) == '0);
    p = '0;
    for (int i = 0; i < WIDTH; i++)
      if (pattern_in[i]) p = PW'(i);
    nxt = (int'(state_out) == N - 1) ? '0 : state_out + SW'(1);
    pat_cur = pat_of(state_out);
    pat_nxt = pat_of(nxt);
    adj_up = {1'b0, p} == {1'b0, prev_p} + (PW+1)'(1);
    adj_dn = {1'b0, prev_p} == {1'b0, p} + (PW+1)'(1);
    if (adj_up)
      lock_s = SW'(p);
    else if (p == '0)
      lock_s = '0;
    else
      lock_s = SW'(N - int'(p));
  end

  always_comb begin
    fsm_n    = fsm;
    prev_n   = prev_p;
    state_n  = state_out;
    dir_n    = dir_out;
    locked_n = locked;
    stall_n  = stall;
    error_n  = 1'b0;
    cnt_n    = err_count;
    if (pattern_valid) begin
      unique case (fsm)
        S_HUNT: begin
          if (onehot) begin
            prev_n = p;
            fsm_n  = S_SYNC;
          end
        end
        S_SYNC: begin
          if (!onehot) begin
            fsm_n = S_HUNT;
          end else if (p == prev_p) begin
            fsm_n = S_SYNC;
          end else if (adj_up || adj_dn) begin
            state_n  = lock_s;
            dir_n    = dir_of(lock_s);
            locked_n = 1'b1;
            stall_n  = 1'b0;
            fsm_n    = S_LOCK;
          end else begin
            prev_n = p;
          end
        end
        S_LOCK: begin
          if (pattern_in == pat_cur) begin
            stall_n = 1'b1;
          end else if (pattern_in == pat_nxt) begin
            state_n = nxt;
            dir_n   = dir_of(nxt);
            stall_n = 1'b0;
          end else begin
            error_n  = 1'b1;
            locked_n = 1'b0;
            stall_n  = 1'b0;
            if (err_count != '1) cnt_n = err_count + ERR_CNT_W'(1);
            if (onehot) begin
              prev_n = p;
              fsm_n  = S_SYNC;
            end else begin
              fsm_n = S_HUNT;
            end
          end
        end
        default: fsm_n = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge slowclk) begin
    if (reset) begin
      fsm       <= S_HUNT;
      prev_p    <= '0;
      state_out <= '0;
      dir_out   <= 1'b1;
      locked    <= 1'b0;
      stall     <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      fsm       <= fsm_n;
      prev_p    <= prev_n;
      state_out <= state_n;
      dir_out   <= dir_n;
      locked    <= locked_n;
      stall     <= stall_n;
      error     <= error_n;
      err_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_larson_pattern_decoder.sv
// Directed bench for larson_pattern_decoder: vector table plus
// hand sequences for hold, reset-while-locked and counter saturation.
module tb_larson_pattern_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pat;
  logic       vld;
  logic [3:0] st, st2;
  logic       dir, lk, stl, er;
  logic       dir2, lk2, stl2, er2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  larson_pattern_decoder dut (
    .slowclk(clk), .reset(reset), .pattern_in(pat),
    .pattern_valid(vld), .state_out(st), .dir_out(dir),
    .locked(lk), .stall(stl), .error(er), .err_count(cnt)
  );

  larson_pattern_decoder #(.ERR_CNT_W(2)) dut2 (
    .slowclk(clk), .reset(reset), .pattern_in(pat),
    .pattern_valid(vld), .state_out(st2), .dir_out(dir2),
    .locked(lk2), .stall(stl2), .error(er2), .err_count(cnt2)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] p;
    int         s;
    int         d;
    int         l;
    int         k;
    int         e;
    int         c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] p,
                              int s, int d, int l, int k, int e, int c);
    vec_t t;
    t.rst = r; t.v = v; t.p = p;
    t.s = s; t.d = d; t.l = l; t.k = k; t.e = e; t.c = c;
    return t;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic v, logic [7:0] p);
    reset = r; vld = v; pat = p;
    @(negedge clk);
  endtask

  task automatic check(string tag, int s, int d, int l, int k,
                       int e, int c);
    int c2;
    c2 = (c > 3) ? 3 : c;
    cmp({tag, " state"}, int'(st), s);
    cmp({tag, " dir"}, int'(dir), d);
    cmp({tag, " locked"}, int'(lk), l);
    cmp({tag, " stall"}, int'(stl), k);
    cmp({tag, " error"}, int'(er), e);
    cmp({tag, " err_count"}, int'(cnt), c);
    cmp({tag, " err_count_w2"}, int'(cnt2), c2);
  endtask

  initial begin
    reset = 1'b1; vld = 1'b1; pat = 8'hFF;
    @(negedge clk);

    // reset with garbage on the bus
    tbl.push_back(mk(1, 1, 8'hFF, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'hFF, 0, 1, 0, 0, 0, 0));
    // full sweep up and back, wrapping to 0
    tbl.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h02, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 3, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h40, 6, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h80, 7, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h40, 8, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 9, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 10, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 11, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 12, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h02, 13, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h02, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 3, 1, 1, 0, 0, 0));
    // hold at state 3
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 8'h08, 3, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 5, 1, 1, 0, 0, 0));
    // backward step is an error; relock going down
    tbl.push_back(mk(0, 1, 8'h08, 5, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8'h04, 12, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h00, 12, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 8'h00, 12, 0, 0, 0, 0, 2));
    // lock on a downward pair
    tbl.push_back(mk(1, 1, 8'h20, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h20, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 10, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 11, 0, 1, 0, 0, 0));
    // multi-hot while locked
    tbl.push_back(mk(0, 1, 8'h0C, 11, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 8'h04, 11, 0, 0, 0, 0, 1));
    // non-adjacent in sync just moves the reference
    tbl.push_back(mk(0, 1, 8'h40, 11, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h80, 7, 0, 1, 0, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].p);
      check($sformatf("vec%0d", i), tbl[i].s, tbl[i].d, tbl[i].l,
            tbl[i].k, tbl[i].e, tbl[i].c);
    end

    // valid low ignores garbage, then reset while locked
    step(1, 1, 8'h00);
    step(0, 1, 8'h01);
    step(0, 1, 8'h02);
    step(0, 1, 8'h04);
    check("lock2", 2, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'hA5);
      check($sformatf("novalid%0d", i), 2, 1, 1, 0, 0, 0);
    end
    reset = 1'b0; vld = 1'b0; pat = 8'hXX;
    @(negedge clk);
    check("novalid_x", 2, 1, 1, 0, 0, 0);
    step(1, 1, 8'h08);
    check("midreset", 0, 1, 0, 0, 0, 0);

    // five forced errors: wide counter 5, narrow one saturates at 3
    step(0, 1, 8'h01);
    step(0, 1, 8'h02);
    step(0, 1, 8'h08);
    check("sat_e1", 1, 1, 0, 0, 1, 1);
    step(0, 1, 8'h10);
    check("sat_l1", 4, 1, 1, 0, 0, 1);
    step(0, 1, 8'h01);
    check("sat_e2", 4, 1, 0, 0, 1, 2);
    step(0, 1, 8'h02);
    step(0, 1, 8'h08);
    check("sat_e3", 1, 1, 0, 0, 1, 3);
    step(0, 1, 8'h10);
    step(0, 1, 8'h01);
    check("sat_e4", 4, 1, 0, 0, 1, 4);
    step(0, 1, 8'h02);
    step(0, 1, 8'h08);
    check("sat_e5", 1, 1, 0, 0, 1, 5);
    step(0, 1, 8'h00);
    check("sat_end", 1, 1, 0, 0, 0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
